ifetch_unit: RTL

Instruction fetch stage directly downstream of the multicycle CPU's PC register. It takes the current PC, runs a request/acknowledge transaction with instruction memory, and holds the fetched word in the instruction register until decode accepts it. While the stage is busy it back-pressures the PC register through `stall`. It also reports misaligned-PC and memory-timeout faults.

---
 rtl/ifetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: runs the imem req/ack handshake for the PC stage,
// holds the fetched word until decode takes it, and latches fetch faults.
module ifetch_unit #(
    parameter logic [31:0] RESET_IR = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
    logic [31:0]   faddr_q, faddr_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          launch;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        code_d     = code_q;
        faddr_d    = faddr_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        launch     = 1'b0;
        stall      = 1'b1;
        unique case (state_q)
            IDLE: begin
                stall  = 1'b0;
                launch = fetch_en & ~flush;
            end
            REQ: begin
                if (imem_ack) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (drop_q | flush) begin
                        state_d = IDLE;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = addr_q;
                        ir_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    state_d = FAULT;
                    fault_d = 1'b1;
                    code_d  = 2'b10;
                    faddr_d = addr_q;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    drop_d = drop_q | flush;
                end
            end
            HOLD: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (ir_ready) begin
                    stall      = 1'b0;
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                    launch     = fetch_en;
                end
            end
            FAULT: begin
            end
        endcase
        // Shared by IDLE and the back-to-back path out of HOLD
        if (launch) begin
            if (pc_in[1:0] != 2'b00) begin
                state_d = FAULT;
                fault_d = 1'b1;
                code_d  = 2'b01;
                faddr_d = pc_in;
            end else begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = pc_in;
                cnt_d   = '0;
                drop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            ir_q       <= RESET_IR;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= 2'b00;
            faddr_q    <= '0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            faddr_q    <= faddr_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ir         = ir_q;
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = ir_valid_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_addr = faddr_q;

endmodule
